// File: rtl/frame_address_sequencer.sv
// Animation frame sequencer and texture-ROM address/brightness pipeline for the POV hologram.
// The displayed frame is latched on the strip's first LED request so a strip never tears.
module frame_address_sequencer #(
    parameter int unsigned CLK_FREQ    = 100_000_000,
    parameter int unsigned FPS         = 15,
    parameter int unsigned LED_COUNT   = 52,
    parameter int unsigned TEX_WIDTH   = 64,
    parameter int unsigned NUM_FRAMES  = 30,
    parameter int unsigned PX_W        = 6,
    parameter int unsigned COL_W       = 6,
    parameter int unsigned ROM_LATENCY = 1
) (
    input  logic                                                  clk,
    input  logic                                                  reset_n,
    input  logic [1:0]                                            mode,
    input  logic                                                  restart,
    input  logic                                                  step,
    input  logic                                                  req_valid,
    input  logic [PX_W-1:0]                                       px_num,
    input  logic [COL_W-1:0]                                      col,
    output logic [$clog2(TEX_WIDTH*LED_COUNT*NUM_FRAMES)-1:0]     rom_addr,
    input  logic [23:0]                                           rom_data,
    input  logic [1:0]                                            brightness,
    output logic [23:0]                                           pixel_out,
    output logic                                                  pixel_valid,
    output logic [7:0]                                            frame_idx,
    output logic                                                  frame_tick,
    output logic                                                  done
);

    localparam int unsigned ADDR_W = $clog2(TEX_WIDTH*LED_COUNT*NUM_FRAMES);
    localparam int unsigned CPF    = CLK_FREQ / FPS;
    localparam int unsigned TMR_W  = (CPF > 1) ? $clog2(CPF) : 1;

    localparam logic [TMR_W-1:0]  TMR_LAST   = TMR_W'(CPF - 1);
    localparam logic [7:0]        LAST_FRAME = 8'(NUM_FRAMES - 1);
    localparam logic [ADDR_W-1:0] FRAME_SIZE = ADDR_W'(LED_COUNT * TEX_WIDTH);
    localparam logic [ADDR_W-1:0] ROW_SIZE   = ADDR_W'(TEX_WIDTH);

    typedef enum logic [1:0] {
        MODE_LOOP    = 2'd0,
        MODE_PING    = 2'd1,
        MODE_ONESHOT = 2'd2,
        MODE_HOLD    = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    mode_e            mode_c;
    mode_e            mode_q;
    logic [TMR_W-1:0] timer_q;
    logic [7:0]       frame_q;
    logic [7:0]       frame_d;
    logic [7:0]       disp_frame_q;
    dir_e             dir_q;
    dir_e             dir_d;
    logic             done_q;
    logic             done_d;
    logic             tick;
    logic             advance;
    logic             mode_chg;

    assign mode_c    = mode_e'(mode);
    assign frame_idx = frame_q;
    assign done      = done_q;

    // NOTE: every signal gets a default at the top so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        mode_chg = (mode_c != mode_q);
        tick     = (mode_c != MODE_HOLD) && (timer_q == TMR_LAST);
        advance  = (mode_c == MODE_HOLD) ? step : tick;
        frame_d  = frame_q;
        dir_d    = dir_q;
        done_d   = done_q && !mode_chg;

        if (advance && !done_d) begin
            case (mode_c)
                MODE_PING: begin
                    if (NUM_FRAMES > 1) begin
                        // Reflect at the ends so each endpoint is shown for exactly one frame period.
                        if ((dir_q == DIR_UP && frame_q != LAST_FRAME) || frame_q == 8'd0)
                            frame_d = frame_q + 8'd1;
                        else
                            frame_d = frame_q - 8'd1;
                    end
                    if (frame_d == LAST_FRAME)
                        dir_d = DIR_DOWN;
                    else if (frame_d == 8'd0)
                        dir_d = DIR_UP;
                end
                MODE_ONESHOT: begin
                    frame_d = (frame_q == LAST_FRAME) ? frame_q : frame_q + 8'd1;
                    done_d  = (frame_d == LAST_FRAME);
                end
                default: begin
                    frame_d = (frame_q == LAST_FRAME) ? 8'd0 : frame_q + 8'd1;
                end
            endcase
        end

        if (restart) begin
            frame_d = 8'd0;
            dir_d   = DIR_UP;
            done_d  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q     <= MODE_LOOP;
            timer_q    <= '0;
            frame_q    <= 8'd0;
            dir_q      <= DIR_UP;
            done_q     <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            mode_q <= mode_c;
            if (restart || mode_c == MODE_HOLD || tick)
                timer_q <= '0;
            else
                timer_q <= timer_q + TMR_W'(1);
            frame_q    <= frame_d;
            dir_q      <= dir_d;
            done_q     <= done_d;
            frame_tick <= (frame_d != frame_q) && !restart;
        end
    end

    logic [7:0]        frame_sel;
    logic              req_in_range;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] pix_addr;

    // The first LED of a strip sees the freshly latched frame, not the stale display frame.
    always_comb begin
        frame_sel    = (req_valid && px_num == '0) ? frame_q : disp_frame_q;
        req_in_range = (32'(px_num) < LED_COUNT) && (32'(col) < TEX_WIDTH);
        base_addr    = ADDR_W'(frame_sel) * FRAME_SIZE;
        pix_addr     = base_addr + ADDR_W'(px_num) * ROW_SIZE + ADDR_W'(col);
    end

    logic [ROM_LATENCY:0] vld_pipe;
    logic [ROM_LATENCY:0] blank_pipe;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            disp_frame_q <= 8'd0;
            rom_addr     <= '0;
            vld_pipe     <= '0;
            blank_pipe   <= '0;
            pixel_out    <= '0;
            pixel_valid  <= 1'b0;
        end else begin
            if (req_valid) begin
                rom_addr <= req_in_range ? pix_addr : base_addr;
                if (px_num == '0)
                    disp_frame_q <= frame_q;
            end
            vld_pipe    <= {vld_pipe[ROM_LATENCY-1:0], req_valid};
            blank_pipe  <= {blank_pipe[ROM_LATENCY-1:0], !req_in_range};
            pixel_valid <= vld_pipe[ROM_LATENCY];
            if (vld_pipe[ROM_LATENCY]) begin
                pixel_out <= blank_pipe[ROM_LATENCY] ? 24'd0 :
                             {rom_data[23:16] >> brightness,
                              rom_data[15:8]  >> brightness,
                              rom_data[7:0]   >> brightness};
            end
        end
    end

endmodule

// File: tb/tb_frame_address_sequencer.sv
// Self-checking bench for frame_address_sequencer: directed sequencer steps plus randomized
// pixel requests scored against an address/pixel reference model and a behavioural ROM.
module tb_frame_address_sequencer;

    localparam int unsigned LEDS   = 52;
    localparam int unsigned TEXW   = 64;
    localparam int unsigned NFR    = 4;
    localparam int unsigned FSZ    = LEDS * TEXW;
    localparam int unsigned ADDR_W = $clog2(TEXW * LEDS * NFR);

    logic              clk        = 1'b0;
    logic              reset_n    = 1'b1;
    logic [1:0]        mode       = 2'd0;
    logic              restart    = 1'b0;
    logic              step       = 1'b0;
    logic              req_valid  = 1'b0;
    logic [5:0]        px_num     = 6'd0;
    logic [5:0]        col        = 6'd0;
    logic [23:0]       rom_data   = 24'd0;
    logic [1:0]        brightness = 2'd0;
    logic [ADDR_W-1:0] rom_addr;
    logic [23:0]       pixel_out;
    logic              pixel_valid;
    logic [7:0]        frame_idx;
    logic              frame_tick;
    logic              done;

    frame_address_sequencer #(
        .CLK_FREQ   (20),
        .FPS        (2),
        .LED_COUNT  (LEDS),
        .TEX_WIDTH  (TEXW),
        .NUM_FRAMES (NFR),
        .PX_W       (6),
        .COL_W      (6),
        .ROM_LATENCY(1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .mode       (mode),
        .restart    (restart),
        .step       (step),
        .req_valid  (req_valid),
        .px_num     (px_num),
        .col        (col),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .brightness (brightness),
        .pixel_out  (pixel_out),
        .pixel_valid(pixel_valid),
        .frame_idx  (frame_idx),
        .frame_tick (frame_tick),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] rom_word(input logic [ADDR_W-1:0] a);
        logic [31:0] t;
        t = 32'(a) * 32'd40503 + 32'd4660;
        return (a == ADDR_W'(327)) ? 24'hFF8040 : t[23:0];
    endfunction

    // One-cycle-latency texture ROM.
    always @(posedge clk) rom_data <= rom_word(rom_addr);

    typedef struct {
        int                due;
        logic              blank;
        logic [ADDR_W-1:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   errors      = 0;
    int   checks      = 0;
    int   cyc         = 0;
    int   model_frame = 0;
    int   model_disp  = 0;
    bit   track       = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [23:0] exp_pixel(input exp_t e, input logic [1:0] b);
        logic [23:0] w;
        if (e.blank) return 24'd0;
        w = rom_word(e.addr);
        return {w[23:16] >> b, w[15:8] >> b, w[7:0] >> b};
    endfunction

    // Advance one clock: record the request driven this cycle, then score outputs #1 after the edge.
    task automatic cycle();
        logic [1:0]        b_used;
        logic [ADDR_W-1:0] a_exp;
        bit                had_req;
        int                fsel;
        int                prev;
        bit                changed;
        exp_t              e;
        b_used  = brightness;
        had_req = 1'b0;
        a_exp   = '0;
        if (req_valid) begin
            fsel = (px_num == 6'd0) ? model_frame : model_disp;
            if (px_num == 6'd0) model_disp = model_frame;
            e.due   = cyc + 3;
            e.blank = (int'(px_num) >= LEDS);
            e.addr  = ADDR_W'(fsel * FSZ + (e.blank ? 0 : int'(px_num) * TEXW + int'(col)));
            exp_q.push_back(e);
            a_exp   = e.addr;
            had_req = 1'b1;
        end
        prev = model_frame;
        if (track && mode == 2'd3 && step) model_frame = (model_frame + 1) % NFR;
        changed = (model_frame != prev);

        @(posedge clk);
        #1;
        cyc++;
        if (had_req) check("rom_addr", 32'(rom_addr), 32'(a_exp));
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            check("pixel_valid", 32'(pixel_valid), 32'd1);
            check("pixel_out", 32'(pixel_out), 32'(exp_pixel(e, b_used)));
        end else begin
            check("pixel_valid_idle", 32'(pixel_valid), 32'd0);
        end
        if (track) begin
            check("hold_frame_idx", 32'(frame_idx), 32'(model_frame));
            check("hold_frame_tick", 32'(frame_tick), 32'(changed));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
        check({tag, "_pixel_out"}, 32'(pixel_out), 32'd0);
        check({tag, "_pixel_valid"}, 32'(pixel_valid), 32'd0);
        check({tag, "_frame_idx"}, 32'(frame_idx), 32'd0);
        check({tag, "_frame_tick"}, 32'(frame_tick), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic pulse_restart(input logic [1:0] m);
        mode    = m;
        restart = 1'b1;
        cycle();
        restart = 1'b0;
    endtask

    initial begin
        // Reset: asserted between edges, outputs must clear without waiting for a clock.
        #2 reset_n = 1'b0;
        #1;
        check_all_zero("reset_async");
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_held");
        reset_n = 1'b1;

        // Loop mode straight out of reset: a tick every 10 cycles.
        for (int k = 1; k <= 45; k++) begin
            cycle();
            check("loop_tick", 32'(frame_tick), (k % 10 == 0) ? 32'd1 : 32'd0);
            check("loop_frame", 32'(frame_idx), 32'((k / 10) % NFR));
        end

        // Ping-pong: 0,1,2,3,2,1,0,1 with each end shown once.
        pulse_restart(2'd1);
        check("pp_restart_frame", 32'(frame_idx), 32'd0);
        for (int k = 1; k <= 70; k++) begin
            int m;
            cycle();
            m = (k / 10) % (2 * (NFR - 1));
            check("pp_tick", 32'(frame_tick), (k % 10 == 0) ? 32'd1 : 32'd0);
            check("pp_frame", 32'(frame_idx), 32'((m <= NFR - 1) ? m : 2 * (NFR - 1) - m));
        end

        // One-shot: stops at the last frame with done held, then restart clears it.
        pulse_restart(2'd2);
        for (int k = 1; k <= 80; k++) begin
            cycle();
            check("os_frame", 32'(frame_idx), 32'((k / 10 < NFR - 1) ? k / 10 : NFR - 1));
            check("os_tick", 32'(frame_tick), (k % 10 == 0 && k <= 30) ? 32'd1 : 32'd0);
            check("os_done", 32'(done), (k >= 30) ? 32'd1 : 32'd0);
        end
        pulse_restart(2'd2);
        check("os_restart_frame", 32'(frame_idx), 32'd0);
        check("os_restart_done", 32'(done), 32'd0);

        // Mode change clears done without touching the frame.
        repeat (30) cycle();
        check("os_done_again", 32'(done), 32'd1);
        mode = 2'd0;
        cycle();
        check("modechg_done", 32'(done), 32'd0);
        check("modechg_frame", 32'(frame_idx), 32'd3);

        // Restart on the same edge as a tick wins: frame 0, no tick, timer restarted.
        pulse_restart(2'd0);
        repeat (9) cycle();
        check("rt_pre_frame", 32'(frame_idx), 32'd0);
        restart = 1'b1;
        cycle();
        restart = 1'b0;
        check("rt_frame", 32'(frame_idx), 32'd0);
        check("rt_tick", 32'(frame_tick), 32'd0);
        for (int k = 1; k <= 10; k++) begin
            cycle();
            check("rt_after_tick", 32'(frame_tick), (k == 10) ? 32'd1 : 32'd0);
        end

        // Hold mode: timer frozen, frames advance only on step (tracked by the model from here).
        pulse_restart(2'd3);
        model_frame = 0;
        track       = 1'b1;
        repeat (25) cycle();
        step = 1'b1;
        cycle();
        cycle();
        step = 1'b0;

        // Tear-free latch: display frame stays 0 until the px_num==0 request.
        brightness = 2'd1;
        req_valid  = 1'b1;
        px_num     = 6'd5;
        col        = 6'd7;
        cycle();
        check("tear_addr_327", 32'(rom_addr), 32'd327);
        px_num = 6'd0;
        col    = 6'd0;
        cycle();
        check("tear_addr_6656", 32'(rom_addr), 32'd6656);
        req_valid = 1'b0;
        cycle();
        check("pix_const_valid", 32'(pixel_valid), 32'd1);
        check("pix_const_value", 32'(pixel_out), 32'h7F4020);
        cycle();

        // Out-of-range LED index gives a blank pixel.
        req_valid = 1'b1;
        px_num    = 6'd60;
        col       = 6'd3;
        cycle();
        req_valid = 1'b0;
        cycle();
        cycle();
        check("blank_valid", 32'(pixel_valid), 32'd1);
        check("blank_value", 32'(pixel_out), 32'd0);

        // Four back-to-back requests; the model expects four consecutive pixel_valid cycles.
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1;
            px_num    = 6'(10 + i);
            col       = 6'(20 + i);
            cycle();
        end
        req_valid = 1'b0;
        repeat (4) cycle();

        // Randomized requests, steps and brightness.
        for (int i = 0; i < 300; i++) begin
            req_valid  = ($urandom_range(0, 3) != 0);
            px_num     = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(0, 63));
            col        = 6'($urandom_range(0, 63));
            step       = ($urandom_range(0, 9) == 0);
            brightness = 2'($urandom_range(0, 3));
            cycle();
        end
        step = 1'b0;

        // Mid-stream async reset drops in-flight pixels.
        req_valid = 1'b1;
        px_num    = 6'd3;
        cycle();
        px_num = 6'd4;
        cycle();
        #2 reset_n = 1'b0;
        #1;
        check_all_zero("reset_mid");
        exp_q.delete();
        model_frame = 0;
        model_disp  = 0;
        req_valid   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (6) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
